// File: rtl/baud_pkg.sv
// Shared types and constants for the multi-channel fractional baud generator.
package baud_pkg;

    // Smallest integer divisor a channel may run with.
    localparam int MIN_DIV    = 2;

    // Default field widths for configuration records.
    localparam int CFG_INT_W  = 16;
    localparam int CFG_FRAC_W = 8;

    // One divisor setting: period = div_int + div_frac / 2^CFG_FRAC_W cycles.
    typedef struct packed {
        logic [CFG_INT_W-1:0]  div_int;
        logic [CFG_FRAC_W-1:0] div_frac;
    } baud_cfg_t;

    // Running state of one channel's divider.
    typedef struct packed {
        logic [CFG_INT_W:0]    cnt;
        logic [CFG_FRAC_W-1:0] frac_acc;
        logic                  carry;
        logic [7:0]            os_cnt;
    } chan_state_t;

endpackage

// File: rtl/baud_chan.sv
// One baud channel: fractional divider, oversample counter and a shadow
// divisor register that is committed on a period boundary.
module baud_chan
    import baud_pkg::*;
#(
    parameter int INT_W        = 16,
    parameter int FRAC_W       = 8,
    parameter int OVERSAMPLE   = 16,
    parameter int DEF_DIV_INT  = 54,
    parameter int DEF_DIV_FRAC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              wr,
    input  logic [INT_W-1:0]  wr_int,
    input  logic [FRAC_W-1:0] wr_frac,
    output logic              pending,
    output logic              os_tick,
    output logic              bit_tick
);

    localparam int                  OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]     OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]     OS_ONE  = OS_W'(1);
    localparam logic [INT_W:0]      CNT_ONE = (INT_W+1)'(1);

    logic [INT_W:0]    cnt;
    logic [INT_W:0]    period;
    logic [FRAC_W-1:0] frac_acc;
    logic [FRAC_W:0]   frac_sum;
    logic              carry;
    logic [OS_W-1:0]   os_cnt;
    logic [INT_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [INT_W-1:0]  sh_int;
    logic [FRAC_W-1:0] sh_frac;
    logic              tick_now;

    // The carry from the previous period stretches the current one by a cycle.
    assign period   = {1'b0, act_int} + {{INT_W{1'b0}}, carry};
    assign frac_sum = {1'b0, frac_acc} + {1'b0, act_frac};
    assign tick_now = en && (cnt == period - CNT_ONE);

    // Period counter, fraction accumulator and oversample counter; strobes are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            frac_acc <= '0;
            carry    <= 1'b0;
            os_cnt   <= '0;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
        end else begin
            os_tick  <= tick_now;
            bit_tick <= tick_now && (os_cnt == OS_LAST);
            if (!en) begin
                cnt      <= '0;
                frac_acc <= '0;
                carry    <= 1'b0;
                os_cnt   <= '0;
            end else if (tick_now) begin
                cnt      <= '0;
                frac_acc <= frac_sum[FRAC_W-1:0];
                carry    <= frac_sum[FRAC_W];
                os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_ONE;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // Shadow capture on write; commit when the period in flight ends, or at once when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_int  <= INT_W'(DEF_DIV_INT);
            act_frac <= FRAC_W'(DEF_DIV_FRAC);
            sh_int   <= '0;
            sh_frac  <= '0;
            pending  <= 1'b0;
        end else if (wr) begin
            sh_int   <= wr_int;
            sh_frac  <= wr_frac;
            pending  <= 1'b1;
        end else if (pending && (tick_now || !en)) begin
            act_int  <= sh_int;
            act_frac <= sh_frac;
            pending  <= 1'b0;
        end
    end

endmodule

// File: rtl/baud_gen_multi.sv
// Multi-channel fractional UART baud generator: configuration decode and
// error reporting around NUM_CH independent baud_chan instances.
module baud_gen_multi
    import baud_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int INT_W        = 16,
    parameter int FRAC_W       = 8,
    parameter int OVERSAMPLE   = 16,
    parameter int DEF_DIV_INT  = 54,
    parameter int DEF_DIV_FRAC = 64,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [INT_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] os_tick,
    output logic [NUM_CH-1:0] bit_tick
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr;
    logic              ch_ok;
    logic              div_ok;

    // Decode a write: ready follows the addressed channel's pending flag.
    always_comb begin
        ch_ok     = (32'(cfg_ch) < NUM_CH);
        div_ok    = (cfg_div_int >= INT_W'(MIN_DIV));
        cfg_ready = 1'b1;
        wr        = '0;
        if (ch_ok) begin
            cfg_ready = !pending[cfg_ch];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            wr[i] = cfg_valid && cfg_ready && ch_ok && div_ok && (32'(cfg_ch) == i);
        end
    end

    // Rejected writes are still accepted, and flagged for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_valid && cfg_ready && !(ch_ok && div_ok);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        baud_chan #(
            .INT_W        (INT_W),
            .FRAC_W       (FRAC_W),
            .OVERSAMPLE   (OVERSAMPLE),
            .DEF_DIV_INT  (DEF_DIV_INT),
            .DEF_DIV_FRAC (DEF_DIV_FRAC)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .en       (en[g]),
            .wr       (wr[g]),
            .wr_int   (cfg_div_int),
            .wr_frac  (cfg_div_frac),
            .pending  (pending[g]),
            .os_tick  (os_tick[g]),
            .bit_tick (bit_tick[g])
        );
    end

endmodule

// File: tb/tb_baud_gen_multi.sv
// Scoreboard bench for baud_gen_multi: a reference divider model predicts the
// cycle and bit flag of every os_tick; a negedge monitor pops and compares.
module tb_baud_gen_multi;
    import baud_pkg::*;

    localparam int NUM_CH = 2;
    localparam int OVS    = 16;
    localparam int FSCALE = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  en = 2'b00;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [0:0]  cfg_ch = 1'b0;
    logic [15:0] cfg_div_int = '0;
    logic [7:0]  cfg_div_frac = '0;
    logic        cfg_err;
    logic [1:0]  os_tick;
    logic [1:0]  bit_tick;

    baud_gen_multi #(
        .NUM_CH       (NUM_CH),
        .INT_W        (16),
        .FRAC_W       (8),
        .OVERSAMPLE   (OVS),
        .DEF_DIV_INT  (54),
        .DEF_DIV_FRAC (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_div_int  (cfg_div_int),
        .cfg_div_frac (cfg_div_frac),
        .cfg_err      (cfg_err),
        .os_tick      (os_tick),
        .bit_tick     (bit_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    typedef struct packed {
        int   t;
        logic bt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int m_last [NUM_CH];
    int m_acc  [NUM_CH];
    int m_carry[NUM_CH];
    int m_os   [NUM_CH];

    function automatic int qsz(input int c);
        return (c == 0) ? q0.size() : q1.size();
    endfunction

    function automatic baud_cfg_t mk(input int di, input int df);
        baud_cfg_t w;
        w.div_int  = di[15:0];
        w.div_frac = df[7:0];
        return w;
    endfunction

    // Channel (re)starts counting from the current cycle with cleared state.
    task automatic model_start(input int c);
        m_last[c]  = cyc;
        m_acc[c]   = 0;
        m_carry[c] = 0;
        m_os[c]    = 0;
    endtask

    // Predict the next n ticks of channel c under divisor di + df/256.
    task automatic push(input int c, input int di, input int df, input int n);
        exp_t e;
        int   sum;
        for (int k = 0; k < n; k++) begin
            m_last[c] += di + m_carry[c];
            sum        = m_acc[c] + df;
            m_carry[c] = (sum >= FSCALE) ? 1 : 0;
            m_acc[c]   = sum % FSCALE;
            e.t        = m_last[c];
            e.bt       = (m_os[c] == OVS - 1);
            m_os[c]    = (m_os[c] == OVS - 1) ? 0 : m_os[c] + 1;
            if (c == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    logic rec0 = 1'b0;
    int   n0 = 0, nb0 = 0, t_a = 0, t_b = 0;

    task automatic mon_ch(input int c);
        exp_t e;
        if (bit_tick[c] && !os_tick[c]) check($sformatf("ch%0d_bit_without_os", c), 1, 0);
        if (os_tick[c]) begin
            if (qsz(c) == 0) begin
                check($sformatf("ch%0d_unexpected_tick_at", c), cyc, -1);
            end else begin
                if (c == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("ch%0d_tick_time", c), cyc, e.t);
                check($sformatf("ch%0d_tick_bit", c), bit_tick[c], e.bt);
            end
        end
    endtask

    // Compare every strobe against the scoreboard, away from the active edge.
    always @(negedge clk) begin
        mon_ch(0);
        mon_ch(1);
        if (rec0 && os_tick[0]) begin
            n0++;
            if (bit_tick[0]) nb0++;
            if (n0 == 1)    t_a = cyc;
            if (n0 == 1025) t_b = cyc;
        end
    end

    task automatic wait_q(input int c, input int target, input int budget);
        int b = budget;
        while (qsz(c) > target && b > 0) begin
            @(negedge clk);
            #1;
            b--;
        end
        check($sformatf("ch%0d_queue_level", c), qsz(c), target);
    endtask

    task automatic cfg_write(input int ch, input baud_cfg_t w);
        @(posedge clk);
        #1;
        cfg_valid    = 1'b1;
        cfg_ch       = 1'(ch);
        cfg_div_int  = w.div_int;
        cfg_div_frac = w.div_frac;
        #1;
        check("cfg_ready_before_write", cfg_ready, 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic chk_rdy(input string tag, input int ch, input int exp);
        cfg_ch = 1'(ch);
        #1;
        check(tag, cfg_ready, exp);
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_os_tick", os_tick, 0);
        check("rst_bit_tick", bit_tick, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        reset = 1'b0;

        // Defaults 54/64 on ch0, long run for the exact average
        @(posedge clk);
        #1;
        rec0  = 1'b1;
        en[0] = 1'b1;
        model_start(0);
        push(0, 54, 64, 1026);
        wait_q(0, 0, 60000);
        rec0 = 1'b0;
        check("span_1024_ticks", t_b - t_a, 55552);
        check("bit_ticks_in_1026", nb0, 64);
        @(posedge clk);
        #1;
        en[0] = 1'b0;

        // Retune ch1 while running: old period finishes, then exactly 10
        @(posedge clk);
        #1;
        en[1] = 1'b1;
        model_start(1);
        push(1, 54, 64, 2);
        wait_q(1, 1, 200);
        cfg_write(1, mk(10, 0));
        check("valid_write_no_err", cfg_err, 0);
        push(1, 10, 0, 24);
        chk_rdy("ch1_ready_while_pending", 1, 0);
        chk_rdy("ch0_ready_during_ch1_pending", 0, 1);
        wait_q(1, 24, 200);
        chk_rdy("ch1_ready_after_commit", 1, 1);
        wait_q(1, 0, 400);
        @(posedge clk);
        #1;
        en[1] = 1'b0;

        // Rejected writes: err pulse, divisor and ticks untouched
        @(posedge clk);
        #1;
        en[0] = 1'b1;
        model_start(0);
        push(0, 54, 64, 40);
        wait_q(0, 37, 400);
        cfg_write(0, mk(1, 0));
        check("err_pulse_div1", cfg_err, 1);
        @(posedge clk);
        #1;
        check("err_one_cycle", cfg_err, 0);
        chk_rdy("nothing_stored_div1", 0, 1);
        cfg_write(0, mk(0, 200));
        check("err_pulse_div0", cfg_err, 1);
        wait_q(0, 0, 3000);

        // Enable low mid-period, retune while idle, restart at 20
        repeat (5) @(posedge clk);
        #1;
        en[0] = 1'b0;
        cfg_write(0, mk(20, 0));
        chk_rdy("ch0_pending_while_idle", 0, 0);
        @(posedge clk);
        #1;
        chk_rdy("ch0_idle_commit", 0, 1);
        repeat (4) @(posedge clk);
        #1;
        en[0] = 1'b1;
        model_start(0);
        push(0, 20, 0, 17);
        wait_q(0, 0, 500);

        // Reset mid-bit with a pending shadow on ch0
        @(posedge clk);
        #1;
        en[1] = 1'b1;
        model_start(1);
        push(1, 10, 0, 60);
        push(0, 20, 0, 50);
        wait_q(0, 47, 400);
        cfg_write(0, mk(30, 0));
        chk_rdy("ch0_pending_before_reset", 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        q0.delete();
        q1.delete();
        check("reset_os_tick", os_tick, 0);
        check("reset_bit_tick", bit_tick, 0);
        chk_rdy("reset_clears_pending", 0, 1);
        @(posedge clk);
        #1;
        check("reset_hold_os_tick", os_tick, 0);
        reset = 1'b0;
        model_start(0);
        model_start(1);
        push(0, 54, 64, 20);
        push(1, 54, 64, 20);
        wait_q(0, 0, 1500);
        wait_q(1, 0, 200);

        // Both channels at 2 + 255/256
        @(posedge clk);
        #1;
        en = 2'b00;
        cfg_write(0, mk(2, 255));
        cfg_write(1, mk(2, 255));
        @(posedge clk);
        #1;
        en = 2'b11;
        model_start(0);
        model_start(1);
        push(0, 2, 255, 300);
        push(1, 2, 255, 300);
        wait_q(0, 0, 1200);
        wait_q(1, 0, 100);
        @(posedge clk);
        #1;
        en = 2'b00;
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
